// File: rtl/fpnew_issue_pkg.sv
// Shared types and widths for the FPNew issue/reorder front end.
// Contents:
//   - field widths of the FPNew input/output interface
//   - status_t: IEEE exception flags in FPNew order {NV,DZ,OF,UF,NX}
//   - rob_entry_t: one reorder-buffer record for the default 64-bit datapath
package fpnew_issue_pkg;

    localparam int unsigned STATUS_W     = 5;
    localparam int unsigned OP_W         = 4;
    localparam int unsigned FMT_W        = 3;
    localparam int unsigned INT_FMT_W    = 2;
    localparam int unsigned RND_W        = 3;
    localparam int unsigned FLEN_DEFAULT = 64;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef struct packed {
        logic [FLEN_DEFAULT-1:0] result;
        status_t                 status;
    } rob_entry_t;

endpackage

// File: rtl/fpnew_rob_mem.sv
// Reorder-buffer payload storage: DEPTH entries of {result, status}.
// Ports:
//   clk                        clock
//   we / waddr                 write strobe and tag-indexed slot
//   wresult / wstatus          payload written on we
//   raddr                      read slot (ROB head)
//   rresult / rstatus          asynchronous read data
// The payload needs no reset: validity is tracked by the done bits in the top.
module fpnew_rob_mem
    import fpnew_issue_pkg::*;
#(
    parameter int unsigned FLEN  = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [FLEN-1:0] wresult,
    input  status_t         wstatus,
    input  logic [AW-1:0]   raddr,
    output logic [FLEN-1:0] rresult,
    output status_t         rstatus
);

    logic [FLEN-1:0] result_mem [DEPTH];
    status_t         status_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            result_mem[waddr] <= wresult;
            status_mem[waddr] <= wstatus;
        end
    end

    assign rresult = result_mem[raddr];
    assign rstatus = status_mem[raddr];

endmodule

// File: rtl/fpnew_issue_rob.sv
// Issue and reorder front end for one FPNew instance.
// Accepts FP requests, tags them with the ROB tail index and drives the FPU input handshake;
// captures tagged FPU results into the ROB and retires them in issue order.
// Ports:
//   clk_i, rst_ni                       clock, synchronous active-low reset
//   req_*                               request stream from the core (valid/ready + op fields)
//   rsp_valid_o/rsp_ready_i             in-order response stream, rsp_result_o/rsp_status_o
//   flush_i                             drop everything in flight; mirrored on fpu_flush_o
//   fpu_*_o / fpu_in_ready_i            FPU input side, fpu_tag_o = allocated slot
//   fpu_*_i / fpu_out_ready_o           FPU output side, always ready
//   outstanding_o, idle_o, err_o        occupancy, idle indication, sticky unknown-tag error
module fpnew_issue_rob
    import fpnew_issue_pkg::*;
#(
    parameter int unsigned FLEN      = 64,
    parameter int unsigned TAG_WIDTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [3*FLEN-1:0]     req_operands_i,
    input  logic [OP_W-1:0]       req_op_i,
    input  logic                  req_op_mod_i,
    input  logic [RND_W-1:0]      req_rnd_mode_i,
    input  logic [FMT_W-1:0]      req_src_fmt_i,
    input  logic [FMT_W-1:0]      req_dst_fmt_i,
    input  logic [INT_FMT_W-1:0]  req_int_fmt_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [FLEN-1:0]       rsp_result_o,
    output logic [STATUS_W-1:0]   rsp_status_o,
    input  logic                  flush_i,
    output logic [3*FLEN-1:0]     fpu_operands_o,
    output logic [OP_W-1:0]       fpu_op_o,
    output logic                  fpu_op_mod_o,
    output logic [RND_W-1:0]      fpu_rnd_mode_o,
    output logic [FMT_W-1:0]      fpu_src_fmt_o,
    output logic [FMT_W-1:0]      fpu_dst_fmt_o,
    output logic [INT_FMT_W-1:0]  fpu_int_fmt_o,
    output logic                  fpu_vectorial_op_o,
    output logic [TAG_WIDTH-1:0]  fpu_tag_o,
    output logic                  fpu_in_valid_o,
    input  logic                  fpu_in_ready_i,
    output logic                  fpu_flush_o,
    input  logic [FLEN-1:0]       fpu_result_i,
    input  logic [STATUS_W-1:0]   fpu_status_i,
    input  logic [TAG_WIDTH-1:0]  fpu_tag_i,
    input  logic                  fpu_out_valid_i,
    output logic                  fpu_out_ready_o,
    input  logic                  fpu_busy_i,
    output logic [TAG_WIDTH:0]    outstanding_o,
    output logic                  idle_o,
    output logic                  err_o
);

    localparam int unsigned      DEPTH     = 2 ** TAG_WIDTH;
    localparam logic [TAG_WIDTH:0] DEPTH_CNT = (TAG_WIDTH + 1)'(DEPTH);

    logic [TAG_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [TAG_WIDTH:0]   count_q, count_d;
    logic [DEPTH-1:0]     alloc_q, alloc_d, done_q, done_d;
    logic                 err_q, err_d;

    logic    can_issue, issue, retire, capture, cap_hit;
    status_t rd_status;

    // Request fields go to the FPU untouched.
    assign fpu_operands_o     = req_operands_i;
    assign fpu_op_o           = req_op_i;
    assign fpu_op_mod_o       = req_op_mod_i;
    assign fpu_rnd_mode_o     = req_rnd_mode_i;
    assign fpu_src_fmt_o      = req_src_fmt_i;
    assign fpu_dst_fmt_o      = req_dst_fmt_i;
    assign fpu_int_fmt_o      = req_int_fmt_i;
    assign fpu_vectorial_op_o = 1'b0;
    assign fpu_tag_o          = tail_q;
    assign fpu_flush_o        = flush_i;
    // Every issued op owns a slot, so results can always be accepted.
    assign fpu_out_ready_o    = 1'b1;

    // No issue while in reset: the FPU is being reset by the same signal.
    // Full blocks issue even if the head retires this cycle (no bypass).
    assign can_issue      = rst_ni && !flush_i && (count_q < DEPTH_CNT);
    assign fpu_in_valid_o = req_valid_i && can_issue;
    assign req_ready_o    = can_issue && fpu_in_ready_i;
    assign issue          = fpu_in_valid_o && fpu_in_ready_i;

    // Response is held back during a flush so no handshake can complete then.
    assign rsp_valid_o = done_q[head_q] && !flush_i;
    assign retire      = rsp_valid_o && rsp_ready_i;

    // Results arriving in a flush cycle belong to discarded ops: ignore silently.
    assign capture = fpu_out_valid_i && !flush_i;
    assign cap_hit = capture && alloc_q[fpu_tag_i] && !done_q[fpu_tag_i];

    assign outstanding_o = count_q;
    assign idle_o        = (count_q == '0) && !fpu_busy_i;
    assign err_o         = err_q;
    assign rsp_status_o  = rd_status;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        alloc_d = alloc_q;
        done_d  = done_q;
        err_d   = err_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            alloc_d = '0;
            done_d  = '0;
        end else begin
            if (issue) begin
                alloc_d[tail_q] = 1'b1;
                tail_d          = tail_q + 1'b1;
            end
            if (cap_hit) begin
                done_d[fpu_tag_i] = 1'b1;
            end else if (capture) begin
                err_d = 1'b1;
            end
            // Retire only touches a done slot, so it never collides with issue or capture.
            if (retire) begin
                alloc_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + 1'b1;
            end
            count_d = count_q + (TAG_WIDTH + 1)'(issue) - (TAG_WIDTH + 1)'(retire);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            alloc_q <= alloc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    fpnew_rob_mem #(
        .FLEN  (FLEN),
        .DEPTH (DEPTH),
        .AW    (TAG_WIDTH)
    ) u_mem (
        .clk     (clk_i),
        .we      (cap_hit),
        .waddr   (fpu_tag_i),
        .wresult (fpu_result_i),
        .wstatus (status_t'(fpu_status_i)),
        .raddr   (head_q),
        .rresult (rsp_result_o),
        .rstatus (rd_status)
    );

endmodule

// File: tb/tb_fpnew_issue_rob.sv
module tb_fpnew_issue_rob;

    localparam int FLEN  = 64;
    localparam int TW    = 2;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              req_valid_i, req_ready_o;
    logic [3*FLEN-1:0] req_operands_i;
    logic [3:0]        req_op_i;
    logic              req_op_mod_i;
    logic [2:0]        req_rnd_mode_i, req_src_fmt_i, req_dst_fmt_i;
    logic [1:0]        req_int_fmt_i;
    logic              rsp_valid_o, rsp_ready_i;
    logic [FLEN-1:0]   rsp_result_o;
    logic [4:0]        rsp_status_o;
    logic              flush_i;
    logic [3*FLEN-1:0] fpu_operands_o;
    logic [3:0]        fpu_op_o;
    logic              fpu_op_mod_o;
    logic [2:0]        fpu_rnd_mode_o, fpu_src_fmt_o, fpu_dst_fmt_o;
    logic [1:0]        fpu_int_fmt_o;
    logic              fpu_vectorial_op_o;
    logic [TW-1:0]     fpu_tag_o;
    logic              fpu_in_valid_o, fpu_in_ready_i, fpu_flush_o;
    logic [FLEN-1:0]   fpu_result_i;
    logic [4:0]        fpu_status_i;
    logic [TW-1:0]     fpu_tag_i;
    logic              fpu_out_valid_i, fpu_out_ready_o, fpu_busy_i;
    logic [TW:0]       outstanding_o;
    logic              idle_o, err_o;

    always #5 clk = ~clk;

    fpnew_issue_rob #(.FLEN(FLEN), .TAG_WIDTH(TW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_operands_i(req_operands_i), .req_op_i(req_op_i), .req_op_mod_i(req_op_mod_i),
        .req_rnd_mode_i(req_rnd_mode_i), .req_src_fmt_i(req_src_fmt_i),
        .req_dst_fmt_i(req_dst_fmt_i), .req_int_fmt_i(req_int_fmt_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o), .flush_i(flush_i),
        .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_op_mod_o(fpu_op_mod_o),
        .fpu_rnd_mode_o(fpu_rnd_mode_o), .fpu_src_fmt_o(fpu_src_fmt_o),
        .fpu_dst_fmt_o(fpu_dst_fmt_o), .fpu_int_fmt_o(fpu_int_fmt_o),
        .fpu_vectorial_op_o(fpu_vectorial_op_o), .fpu_tag_o(fpu_tag_o),
        .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
        .fpu_flush_o(fpu_flush_o), .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
        .fpu_tag_i(fpu_tag_i), .fpu_out_valid_i(fpu_out_valid_i),
        .fpu_out_ready_o(fpu_out_ready_o), .fpu_busy_i(fpu_busy_i),
        .outstanding_o(outstanding_o), .idle_o(idle_o), .err_o(err_o)
    );

    // Reference model: ops in issue order, plus the set still inside the FPU.
    typedef struct {
        logic [63:0] res;
        logic [4:0]  st;
        int          tag;
        bit          done;
    } op_t;

    op_t rob_q[$];
    op_t fpu_q[$];
    int  m_tail;
    bit  m_err;
    bit  st_rand;
    int  n_cmp = 0;
    int  n_mis = 0;

    function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) + $bitstoreal(b));
    endfunction

    function automatic int find_fpu(input int tag);
        foreach (fpu_q[i]) if (fpu_q[i].tag == tag) return i;
        return 0;
    endfunction

    task automatic idle_inputs();
        req_valid_i = 0; rsp_ready_i = 0; flush_i = 0; fpu_out_valid_i = 0;
        fpu_in_ready_i = 1; fpu_busy_i = 0; fpu_tag_i = 0; fpu_result_i = 0; fpu_status_i = 0;
    endtask

    task automatic set_req(input logic [63:0] a, input logic [63:0] b);
        req_operands_i = {b, a, 64'h0};
        req_op_i = 4'd2; req_op_mod_i = 0; req_rnd_mode_i = 0;
        req_src_fmt_i = 3'd1; req_dst_fmt_i = 3'd1; req_int_fmt_i = 2'd3;
    endtask

    task automatic set_rand_req();
        req_operands_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        req_op_i = 4'($urandom); req_op_mod_i = 1'($urandom); req_rnd_mode_i = 3'($urandom);
        req_src_fmt_i = 3'($urandom); req_dst_fmt_i = 3'($urandom); req_int_fmt_i = 2'($urandom);
    endtask

    // Bench-side FPU: present the k-th in-flight op's result this cycle.
    task automatic fpu_return(input int k);
        fpu_out_valid_i = 1;
        fpu_tag_i       = 2'(fpu_q[k].tag);
        fpu_result_i    = fpu_q[k].res;
        fpu_status_i    = fpu_q[k].st;
        fpu_q.delete(k);
    endtask

    // Advance one clock, updating the model from the inputs applied this cycle.
    task automatic tick();
        bit can, iss, ret, hit;
        op_t o;
        can = (rob_q.size() < DEPTH) && !flush_i;
        iss = req_valid_i && can && fpu_in_ready_i;
        ret = !flush_i && rob_q.size() > 0 && rob_q[0].done && rsp_ready_i;
        if (fpu_out_valid_i && !flush_i) begin
            hit = 0;
            foreach (rob_q[i])
                if (rob_q[i].tag == int'(fpu_tag_i) && !rob_q[i].done) begin
                    rob_q[i].done = 1; hit = 1;
                end
            if (!hit) m_err = 1;
        end
        if (ret) void'(rob_q.pop_front());
        if (iss) begin
            o.res  = fp_add(req_operands_i[127:64], req_operands_i[191:128]);
            o.st   = st_rand ? 5'($urandom) : 5'd0;
            o.tag  = m_tail;
            o.done = 0;
            rob_q.push_back(o);
            fpu_q.push_back(o);
            m_tail = (m_tail + 1) % DEPTH;
        end
        if (flush_i) begin
            rob_q.delete(); fpu_q.delete(); m_tail = 0;
        end
        @(posedge clk); #1;
        fpu_out_valid_i = 0;
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_ni = 1;
        rob_q.delete(); fpu_q.delete(); m_tail = 0; m_err = 0;
        #1;
    endtask

    // Retire everything the model holds, checking order and payload.
    task automatic drain(input string name);
        rsp_ready_i = 1; req_valid_i = 0;
        for (int c = 0; c < 16 && rob_q.size() > 0; c++) begin
            n_cmp++;
            if (rsp_valid_o !== rob_q[0].done) begin
                n_mis++; $display("FAIL %s rsp_valid: got %b want %b", name, rsp_valid_o, rob_q[0].done);
            end
            if (rob_q[0].done) begin
                n_cmp++;
                if (rsp_result_o !== rob_q[0].res || rsp_status_o !== rob_q[0].st) begin
                    n_mis++;
                    $display("FAIL %s rsp data: got %h/%h want %h/%h", name, rsp_result_o,
                             rsp_status_o, rob_q[0].res, rob_q[0].st);
                end
            end
            n_cmp++;
            if (outstanding_o !== 3'(rob_q.size()) ||
                req_ready_o !== (rob_q.size() < DEPTH && fpu_in_ready_i)) begin
                n_mis++;
                $display("FAIL %s occupancy: got out=%0d rdy=%b want out=%0d", name,
                         outstanding_o, req_ready_o, rob_q.size());
            end
            tick();
        end
        n_cmp++;
        if (outstanding_o !== 3'd0 || rsp_valid_o !== 1'b0) begin
            n_mis++; $display("FAIL %s drain end: got out=%0d rv=%b want 0/0", name, outstanding_o, rsp_valid_o);
        end
        rsp_ready_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 0; req_valid_i = 1; set_rand_req();
        #1;
        n_cmp++;
        if (req_ready_o !== 1'b0 || fpu_in_valid_o !== 1'b0) begin
            n_mis++; $display("FAIL reset issue gate: got rdy=%b v=%b want 0/0", req_ready_o, fpu_in_valid_o);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (outstanding_o !== 3'd0 || rsp_valid_o !== 1'b0 || err_o !== 1'b0 || fpu_flush_o !== 1'b0) begin
            n_mis++;
            $display("FAIL reset state: got out=%0d rv=%b err=%b fl=%b want 0", outstanding_o,
                     rsp_valid_o, err_o, fpu_flush_o);
        end
        rst_ni = 1; req_valid_i = 0;
        rob_q.delete(); fpu_q.delete(); m_tail = 0; m_err = 0;
        #1;
        n_cmp++;
        if (idle_o !== 1'b1 || fpu_tag_o !== 2'd0 || fpu_out_ready_o !== 1'b1) begin
            n_mis++; $display("FAIL reset idle: got idle=%b tag=%0d ordy=%b want 1/0/1", idle_o, fpu_tag_o, fpu_out_ready_o);
        end
    endtask

    task automatic test_add_latency();
        do_reset();
        st_rand = 0;
        set_req(64'h3FF0000000000000, 64'h4000000000000000);
        req_valid_i = 1;
        #1;
        n_cmp++;
        if (fpu_in_valid_o !== 1'b1 || req_ready_o !== 1'b1 || fpu_tag_o !== 2'd0 ||
            fpu_vectorial_op_o !== 1'b0 || fpu_operands_o !== req_operands_i) begin
            n_mis++;
            $display("FAIL add issue: got v=%b rdy=%b tag=%0d vec=%b", fpu_in_valid_o, req_ready_o,
                     fpu_tag_o, fpu_vectorial_op_o);
        end
        tick();                              // cycle 0: accepted
        req_valid_i = 0;
        fpu_return(0);                       // cycle 1: 1-stage FPU returns
        #1;
        n_cmp++;
        if (rsp_valid_o !== 1'b0 || outstanding_o !== 3'd1) begin
            n_mis++; $display("FAIL add cycle1: got rv=%b out=%0d want 0/1", rsp_valid_o, outstanding_o);
        end
        tick();
        rsp_ready_i = 1;                     // cycle 2: response visible
        #1;
        n_cmp++;
        if (rsp_valid_o !== 1'b1 || rsp_result_o !== 64'h4008000000000000 || rsp_status_o !== 5'd0) begin
            n_mis++;
            $display("FAIL add cycle2: got rv=%b res=%h st=%h want 1/4008000000000000/00",
                     rsp_valid_o, rsp_result_o, rsp_status_o);
        end
        tick();
        n_cmp++;
        if (outstanding_o !== 3'd0 || rsp_valid_o !== 1'b0 || idle_o !== 1'b1) begin
            n_mis++; $display("FAIL add retire: got out=%0d rv=%b idle=%b want 0/0/1", outstanding_o, rsp_valid_o, idle_o);
        end
        rsp_ready_i = 0;
    endtask

    task automatic test_full_wrap();
        logic [3*FLEN-1:0] fifth;
        do_reset();
        st_rand = 1;
        for (int i = 0; i < 4; i++) begin
            set_rand_req(); req_valid_i = 1;
            #1;
            n_cmp++;
            if (req_ready_o !== 1'b1 || fpu_tag_o !== 2'(i)) begin
                n_mis++; $display("FAIL full issue %0d: got rdy=%b tag=%0d want 1/%0d", i, req_ready_o, fpu_tag_o, i);
            end
            tick();
        end
        set_rand_req(); fifth = req_operands_i;
        #1;
        n_cmp++;
        if (req_ready_o !== 1'b0 || fpu_in_valid_o !== 1'b0 || outstanding_o !== 3'd4) begin
            n_mis++;
            $display("FAIL full block: got rdy=%b v=%b out=%0d want 0/0/4", req_ready_o, fpu_in_valid_o, outstanding_o);
        end
        req_valid_i = 0;
        for (int i = 0; i < 4; i++) begin
            fpu_return(0);
            tick();
        end
        drain("full_drain");
        req_operands_i = fifth; req_valid_i = 1;
        #1;
        n_cmp++;
        if (fpu_tag_o !== 2'd0 || fpu_in_valid_o !== 1'b1) begin
            n_mis++; $display("FAIL wrap tag: got tag=%0d v=%b want 0/1", fpu_tag_o, fpu_in_valid_o);
        end
        tick();
        req_valid_i = 0;
        fpu_return(0); tick();
        drain("wrap_drain");
    endtask

    task automatic test_ooo();
        int order [3];
        order = '{2, 0, 1};
        do_reset();
        st_rand = 1;
        for (int i = 0; i < 3; i++) begin
            set_rand_req(); req_valid_i = 1; #1; tick();
        end
        req_valid_i = 0;
        foreach (order[j]) begin
            fpu_return(find_fpu(order[j]));
            #1;
            n_cmp++;
            if (rsp_valid_o !== rob_q[0].done) begin
                n_mis++; $display("FAIL ooo valid step %0d: got %b want %b", j, rsp_valid_o, rob_q[0].done);
            end
            tick();
        end
        drain("ooo_drain");
    endtask

    task automatic test_flush();
        do_reset();
        st_rand = 1;
        for (int i = 0; i < 3; i++) begin
            set_rand_req(); req_valid_i = 1; #1; tick();
        end
        set_rand_req();
        flush_i = 1; rsp_ready_i = 1;
        fpu_return(find_fpu(1));
        #1;
        n_cmp++;
        if (fpu_flush_o !== 1'b1 || fpu_in_valid_o !== 1'b0 || req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            n_mis++;
            $display("FAIL flush cycle: got fl=%b v=%b rdy=%b rv=%b want 1/0/0/0", fpu_flush_o,
                     fpu_in_valid_o, req_ready_o, rsp_valid_o);
        end
        tick();
        flush_i = 0; req_valid_i = 0; rsp_ready_i = 0;
        #1;
        n_cmp++;
        if (outstanding_o !== 3'd0 || err_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            n_mis++; $display("FAIL flush after: got out=%0d err=%b rv=%b want 0/0/0", outstanding_o, err_o, rsp_valid_o);
        end
        set_rand_req(); req_valid_i = 1;
        #1;
        n_cmp++;
        if (fpu_tag_o !== 2'd0 || fpu_in_valid_o !== 1'b1) begin
            n_mis++; $display("FAIL flush retag: got tag=%0d v=%b want 0/1", fpu_tag_o, fpu_in_valid_o);
        end
        tick();
        req_valid_i = 0;
        fpu_return(0); tick();
        drain("flush_drain");
    endtask

    task automatic test_err();
        do_reset();
        fpu_out_valid_i = 1; fpu_tag_i = 2'd3; fpu_result_i = {$urandom, $urandom}; fpu_status_i = 5'h1f;
        tick();
        n_cmp++;
        if (err_o !== 1'b1 || rsp_valid_o !== 1'b0 || outstanding_o !== 3'd0) begin
            n_mis++; $display("FAIL err set: got err=%b rv=%b out=%0d want 1/0/0", err_o, rsp_valid_o, outstanding_o);
        end
        repeat (3) tick();
        fpu_busy_i = 1;
        #1;
        n_cmp++;
        if (err_o !== 1'b1 || idle_o !== 1'b0) begin
            n_mis++; $display("FAIL err sticky: got err=%b idle=%b want 1/0", err_o, idle_o);
        end
        fpu_busy_i = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        st_rand = 1;
        for (int i = 0; i < 2; i++) begin
            set_rand_req(); req_valid_i = 1; #1; tick();
        end
        req_valid_i = 0;
        fpu_return(0); tick();
        fpu_return(0); tick();
        set_rand_req(); req_valid_i = 1; rsp_ready_i = 1;
        #1;
        n_cmp++;
        if (fpu_in_valid_o !== 1'b1 || rsp_valid_o !== 1'b1 || fpu_tag_o !== 2'd2 ||
            rsp_result_o !== rob_q[0].res) begin
            n_mis++;
            $display("FAIL b2b before: got v=%b rv=%b tag=%0d res=%h want 1/1/2/%h", fpu_in_valid_o,
                     rsp_valid_o, fpu_tag_o, rsp_result_o, rob_q[0].res);
        end
        tick();
        req_valid_i = 0; rsp_ready_i = 0;
        #1;
        n_cmp++;
        if (outstanding_o !== 3'd2 || fpu_tag_o !== 2'd3 || rsp_result_o !== rob_q[0].res) begin
            n_mis++;
            $display("FAIL b2b after: got out=%0d tag=%0d res=%h want 2/3/%h", outstanding_o,
                     fpu_tag_o, rsp_result_o, rob_q[0].res);
        end
        fpu_return(0); tick();
        drain("b2b_drain");
    endtask

    task automatic test_random();
        bit exp_can, exp_rv;
        do_reset();
        st_rand = 1;
        for (int c = 0; c < 400; c++) begin
            set_rand_req();
            req_valid_i    = 1'($urandom);
            fpu_in_ready_i = ($urandom % 4) != 0;
            rsp_ready_i    = 1'($urandom);
            flush_i        = ($urandom % 40) == 0;
            fpu_busy_i     = 1'($urandom);
            if (fpu_q.size() > 0 && $urandom % 2 == 1) fpu_return($urandom_range(0, fpu_q.size() - 1));
            #1;
            exp_can = rob_q.size() < DEPTH && !flush_i;
            exp_rv  = !flush_i && rob_q.size() > 0 && rob_q[0].done;
            n_cmp++;
            if (req_ready_o !== (exp_can && fpu_in_ready_i) || fpu_in_valid_o !== (exp_can && req_valid_i) ||
                fpu_tag_o !== 2'(m_tail) || fpu_flush_o !== flush_i) begin
                n_mis++;
                $display("FAIL rand issue c%0d: got rdy=%b v=%b tag=%0d fl=%b want %b/%b/%0d/%b", c,
                         req_ready_o, fpu_in_valid_o, fpu_tag_o, fpu_flush_o,
                         exp_can && fpu_in_ready_i, exp_can && req_valid_i, m_tail, flush_i);
            end
            n_cmp++;
            if (rsp_valid_o !== exp_rv || (exp_rv && (rsp_result_o !== rob_q[0].res ||
                rsp_status_o !== rob_q[0].st))) begin
                n_mis++;
                $display("FAIL rand rsp c%0d: got rv=%b res=%h st=%h want rv=%b", c, rsp_valid_o,
                         rsp_result_o, rsp_status_o, exp_rv);
            end
            n_cmp++;
            if (outstanding_o !== 3'(rob_q.size()) || err_o !== m_err ||
                idle_o !== (rob_q.size() == 0 && !fpu_busy_i)) begin
                n_mis++;
                $display("FAIL rand state c%0d: got out=%0d err=%b idle=%b want out=%0d err=%b", c,
                         outstanding_o, err_o, idle_o, rob_q.size(), m_err);
            end
            n_cmp++;
            if ({fpu_op_o, fpu_op_mod_o, fpu_rnd_mode_o, fpu_src_fmt_o, fpu_dst_fmt_o, fpu_int_fmt_o} !==
                {req_op_i, req_op_mod_i, req_rnd_mode_i, req_src_fmt_i, req_dst_fmt_i, req_int_fmt_i}) begin
                n_mis++; $display("FAIL rand passthrough c%0d: got op=%h want %h", c, fpu_op_o, req_op_i);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        m_tail = 0; m_err = 0; st_rand = 0;
        test_reset();
        test_add_latency();
        test_full_wrap();
        test_ooo();
        test_flush();
        test_err();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fpnew_issue_rob.md
Name: fpnew_issue_rob

Overview:
- Initiator-side companion to the FPNew blackbox wrapper: accepts FP operation requests from an accelerator core, assigns tags, and drives the FPU input handshake.
- Collects FPU results via the tag-indexed output handshake, reorders them into issue order, and presents them on a response stream.
- Sits between core command logic and one FPNew instance; owns tag allocation, outstanding-op tracking and flush sequencing.

Parameters:
- FLEN, 64, operand/result width; must match the FPU instance.
- TAG_WIDTH, 2, FPU tag width; reorder buffer (ROB) depth DEPTH = 2**TAG_WIDTH.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_valid_i / req_ready_o  in/out  1  request handshake
- req_operands_i  in  3*FLEN  operands {op2,op1,op0}, passed to FPU unmodified
- req_op_i  in  4  fpnew operation encoding
- req_op_mod_i  in  1  operation modifier
- req_rnd_mode_i  in  3  rounding mode
- req_src_fmt_i, req_dst_fmt_i  in  3 each  FP formats
- req_int_fmt_i  in  2  integer format
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake
- rsp_result_o  out  FLEN  result
- rsp_status_o  out  5  status flags {NV,DZ,OF,UF,NX}
- flush_i  in  1  discard all in-flight and buffered ops
- fpu_operands_o, fpu_op_o, fpu_op_mod_o, fpu_rnd_mode_o, fpu_src_fmt_o, fpu_dst_fmt_o, fpu_int_fmt_o  out  as req_*  FPU input fields
- fpu_vectorial_op_o  out  1  tied 0
- fpu_tag_o  out  TAG_WIDTH  issued tag
- fpu_in_valid_o / fpu_in_ready_i  out/in  1  FPU input handshake
- fpu_flush_o  out  1  FPU flush
- fpu_result_i  in  FLEN; fpu_status_i  in  5; fpu_tag_i  in  TAG_WIDTH  FPU outputs
- fpu_out_valid_i / fpu_out_ready_o  in/out  1  FPU output handshake
- fpu_busy_i  in  1  FPU busy
- outstanding_o  out  TAG_WIDTH+1  slots allocated (issued, not retired)
- idle_o  out  1  outstanding_o==0 and !fpu_busy_i
- err_o  out  1  sticky: result for unallocated tag

Behaviour:
- Reset (rst_ni=0 at posedge): head=tail=0, count=0, all slot_alloc/slot_done=0, err_o=0; rsp_valid_o=0, fpu_in_valid_o=0, fpu_flush_o=0, req_ready_o=0, outstanding_o=0.
- Issue: can_issue = count<DEPTH && !flush_i. fpu_in_valid_o = req_valid_i && can_issue; req_ready_o = can_issue && fpu_in_ready_i. Request fields pass through combinationally; fpu_tag_o = tail. On issue (fpu_in_valid_o && fpu_in_ready_i): slot_alloc[tail]=1, tail++ (mod DEPTH wrap).
- Capture: fpu_out_ready_o = 1 (each slot is reserved at issue, so the ROB never overflows). On fpu_out_valid_i: if slot_alloc[tag] && !slot_done[tag], write result/status, set slot_done[tag]; otherwise drop the result and set err_o.
- Retire: rsp_valid_o = slot_done[head] (registered state); rsp_result_o/rsp_status_o read slot[head]. On rsp_valid_o && rsp_ready_i: clear alloc/done[head], head++.
- Latency: result captured in cycle N appears on rsp_valid_o at N+1. With FPU PIPELINE_STAGES=1, request accepted at cycle 0 gives rsp_valid_o at cycle 2.
- count = count + issue - retire in the same cycle. Full: count==DEPTH blocks issue even if a retire occurs that cycle (no bypass). Empty: rsp_valid_o=0.
- Out-of-order FPU returns are allowed; responses always leave in issue order.
- Flush: fpu_flush_o = flush_i (combinational). In the flush cycle: no issue, no retire, any FPU result is ignored (err_o not set). Next cycle: pointers, count, alloc/done cleared. Flush with empty ROB is a no-op.
- Reset mid-operation: state cleared as above; the FPU is reset by the same rst_ni.

Decomposition:
- Package fpnew_issue_pkg: STATUS_W=5, OP_W=4, FMT_W=3, INT_FMT_W=2, RND_W=3; a status struct; a rob_entry_t {result, status}.
- Sub-module fpnew_rob_mem: DEPTH x (FLEN+5) storage, 1 write port (tag-indexed), 1 async read port (head).

Test Plan:
- FP64 ADD with op1=0x3FF0000000000000 and op2=0x4000000000000000 (1.0+2.0), accepted cycle 0 with 1-stage FPU -> rsp_result_o=0x4008000000000000, status=0, rsp_valid_o at cycle 2.
- Issue 4 ops with rsp_ready_i=0 -> 5th request sees req_ready_o=0 and outstanding_o=4. Raise rsp_ready_i -> 4 responses in tag order 0,1,2,3, then the 5th issues with tag 0 (wrap).
- FPU model returns tags 2,0,1 -> responses emitted in order 0,1,2 with matching results.
- Issue 3 ops, assert flush_i for one cycle while a result returns -> fpu_flush_o=1, no response, outstanding_o=0 next cycle, err_o=0. A new request then gets tag 0.
- Inject fpu_out_valid_i with tag 3 while idle -> err_o=1 and stays 1, rsp_valid_o=0.
- Simultaneous issue and retire at count=2 -> count remains 2 and tail/head both advance.
